// File: rtl/bcd_counter_ndigit.sv
// bcd_counter_ndigit: N-digit cascaded BCD up/down counter with synchronous
// parallel load, an internal prescaler that produces a one-cycle count-enable
// tick, and per-digit active-low 7-segment decode. Single clock domain.
//
// Build option: define BCD_COUNTER_SATURATE_EN to make the counter saturate at
// all-9s (up) / all-0s (down) instead of wrapping; wrap then pulses on every
// blocked step.
module bcd_counter_ndigit #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned DIV_COUNT = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  tick_led,
  output logic                  wrap
);

  localparam int unsigned    PW       = $clog2(DIV_COUNT);
  localparam logic [PW-1:0]  PRE_LAST = PW'(DIV_COUNT - 1);

`ifdef BCD_COUNTER_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  logic [PW-1:0]         presc;
  logic                  tick;
  logic [4*DIGITS-1:0]   cnt_step;
  logic [4*DIGITS-1:0]   cnt_load;
  logic                  terminal;
  logic                  carry;
  logic [3:0]            cur_digit;
  logic [3:0]            ld_digit;

  // Active-low segment pattern {a,b,c,d,e,f,g}; non-BCD codes blank the digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Prescaler terminal value marks the one-cycle tick.
  always_comb begin
    tick = (presc == PRE_LAST);
  end

  // Next count for one step (carry/borrow ripples through all digits) and the
  // clamped load value; a carry out of the top digit flags the terminal count.
  always_comb begin
    cnt_step  = '0;
    cnt_load  = '0;
    carry     = 1'b1;
    cur_digit = '0;
    ld_digit  = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      cur_digit = count_bcd[4*i +: 4];
      ld_digit  = data_in[4*i +: 4];
      cnt_load[4*i +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;
      if (!carry) begin
        cnt_step[4*i +: 4] = cur_digit;
      end else if (up_down) begin
        if (cur_digit >= 4'd9) begin
          cnt_step[4*i +: 4] = 4'd0;
        end else begin
          cnt_step[4*i +: 4] = cur_digit + 4'd1;
          carry = 1'b0;
        end
      end else begin
        if (cur_digit == 4'd0) begin
          cnt_step[4*i +: 4] = 4'd9;
        end else begin
          cnt_step[4*i +: 4] = cur_digit - 4'd1;
          carry = 1'b0;
        end
      end
    end
    terminal = carry;
  end

  // Registered state: rst > load > (tick & enable) step > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_bcd <= '0;
      presc     <= '0;
      tick_led  <= 1'b0;
      wrap      <= 1'b0;
    end else if (load) begin
      count_bcd <= cnt_load;
      presc     <= '0;
      wrap      <= 1'b0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        tick_led <= ~tick_led;
      end
      wrap <= tick && enable && terminal;
      if (tick && enable && !(SATURATE && terminal)) begin
        count_bcd <= cnt_step;
      end
    end
  end

  // Per-digit segment decode, combinational from the registered count.
  always_comb begin
    seg = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      seg[7*i +: 7] = seg_decode(count_bcd[4*i +: 4]);
    end
  end

endmodule
